// File: rtl/gate_bank_arbiter_pkg.sv
// Shared definitions for the gate bank arbiter: FSM encoding, default lane
// inversion mask, default burst length and a small index-wrap helper.
package gate_bank_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } arb_state_t;

   // Lanes 0,5,6,7 invert, lanes 1-4 buffer.
   localparam logic [7:0] DEF_INV_MASK = 8'hE1;
   localparam int         DEF_BURST    = 2;

   // Next requester index modulo n (n <= 8).
   function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input int n);
      if (int'(idx) >= n - 1) return 3'd0;
      return idx + 3'd1;
   endfunction

endpackage

// File: rtl/gate_bank_arbiter_rr_pick.sv
// Circular first-valid search: starting at 'start', return a one-hot grant
// for the first asserted request and flag whether any was found.
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  logic [2:0]   start,
   output logic [N-1:0] grant,
   output logic         found
);

   int pos;

   // Scan offsets 0..N-1 from start; the first hit wins and blocks the rest.
   always_comb begin
      grant = '0;
      found = 1'b0;
      pos   = 0;
      for (int k = 0; k < N; k++) begin
         pos = int'(start) + k;
         if (pos >= N) pos = pos - N;
         for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i == pos)) begin
               grant[i] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/gate_bank_arbiter.sv
// Gate bank arbiter: N_REQ byte requesters share one registered 8-lane
// inversion/buffer bank. Round-robin arbitration with burst ownership.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no owner; grant first valid requester scanning from ptr
// ST_OWN  | owner holds the bank; cnt transfers accepted so far (1..BURST)
module gate_bank_arbiter
   import gate_bank_arbiter_pkg::*;
#(
   parameter int         N_REQ    = 4,
   parameter logic [7:0] INV_MASK = DEF_INV_MASK,
   parameter int         BURST    = DEF_BURST
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]     req_ready,
   output logic                 out_valid,
   output logic [7:0]           out_data,
   output logic [2:0]           out_id,
   input  logic                 out_ready,
   output logic [15:0]          xfer_count
);

   arb_state_t       state, state_n;
   logic [2:0]       ptr, ptr_n;
   logic [2:0]       owner, owner_n;
   logic [3:0]       cnt, cnt_n;

   logic             load;
   logic             xfer;
   logic             own_keep;
   logic [N_REQ-1:0] own_oh;
   logic [N_REQ-1:0] rr_grant;
   logic             rr_found;
   logic [2:0]       pick_start;
   logic [N_REQ-1:0] grant;
   logic [7:0]       sel_data;
   logic [2:0]       sel_id;

   assign load = !out_valid || out_ready;

   // Owner one-hot; the owner keeps the bank only while it stays valid.
   always_comb begin
      own_oh = '0;
      for (int i = 0; i < N_REQ; i++) begin
         own_oh[i] = (owner == 3'(i));
      end
   end

   assign own_keep   = (state == ST_OWN) && (|(req_valid & own_oh));
   // A dropped owner hands the search to its successor in the same cycle.
   assign pick_start = (state == ST_OWN) ? wrap_inc(owner, N_REQ) : ptr;

   rr_pick #(.N(N_REQ)) u_pick (
      .req   (req_valid),
      .start (pick_start),
      .grant (rr_grant),
      .found (rr_found)
   );

   assign grant     = own_keep ? own_oh : rr_grant;
   assign req_ready = (load && !rst) ? grant : '0;
   assign xfer      = |(req_valid & req_ready);

   // Byte and index of the granted requester.
   always_comb begin
      sel_data = 8'h00;
      sel_id   = 3'd0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_data = req_data[8*i +: 8];
            sel_id   = 3'(i);
         end
      end
   end

   // Next-state: ownership, burst count and round-robin pointer.
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      owner_n = owner;
      cnt_n   = cnt;
      if (load) begin
         if (own_keep) begin
            if (int'(cnt) + 1 >= BURST) begin
               state_n = ST_IDLE;
               ptr_n   = wrap_inc(owner, N_REQ);
               cnt_n   = 4'd0;
            end else begin
               cnt_n = cnt + 4'd1;
            end
         end else begin
            if (state == ST_OWN) begin
               state_n = ST_IDLE;
               ptr_n   = wrap_inc(owner, N_REQ);
               cnt_n   = 4'd0;
            end
            if (rr_found) begin
               if (BURST == 1) begin
                  state_n = ST_IDLE;
                  ptr_n   = wrap_inc(sel_id, N_REQ);
                  cnt_n   = 4'd0;
               end else begin
                  state_n = ST_OWN;
                  owner_n = sel_id;
                  cnt_n   = 4'd1;
               end
            end
         end
      end
   end

   // Arbiter state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         ptr   <= 3'd0;
         owner <= 3'd0;
         cnt   <= 4'd0;
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
         owner <= owner_n;
         cnt   <= cnt_n;
      end
   end

   // Output slot: reloads whenever empty or drained, holds while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= 8'h00;
         out_id    <= 3'd0;
      end else if (load) begin
         out_valid <= xfer;
         if (xfer) begin
            out_data <= sel_data ^ INV_MASK;
            out_id   <= sel_id;
         end
      end
   end

   // Wrapping count of accepted transfers.
   always_ff @(posedge clk) begin
      if (rst) begin
         xfer_count <= 16'h0000;
      end else if (xfer) begin
         xfer_count <= xfer_count + 16'h0001;
      end
   end

endmodule

// File: tb/tb_gate_bank_arbiter.sv
// Bench for gate_bank_arbiter: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model.
module tb_gate_bank_arbiter;

   localparam int         N     = 4;
   localparam logic [7:0] MASK  = 8'hE1;
   localparam int         BURST = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic           out_valid;
   logic [7:0]     out_data;
   logic [2:0]     out_id;
   logic           out_ready;
   logic [15:0]    xfer_count;

   always #5 clk = ~clk;

   gate_bank_arbiter #(.N_REQ(N), .INV_MASK(MASK), .BURST(BURST)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_id     (out_id),
      .out_ready  (out_ready),
      .xfer_count (xfer_count)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: owner = -1 means nobody owns the bank.
   logic        m_ov;
   logic [7:0]  m_data;
   int          m_id;
   int          m_owner;
   int          m_cnt;
   int          m_ptr;
   int          m_count;
   int          m_g;

   function automatic bit vbit(input int idx);
      logic [N-1:0] t;
      t = req_valid >> idx;
      return t[0];
   endfunction

   function automatic logic [7:0] vbyte(input int idx);
      logic [8*N-1:0] t;
      t = req_data >> (8 * idx);
      return t[7:0];
   endfunction

   function automatic int model_grant();
      int start;
      if (rst) return -1;
      if (m_ov && !out_ready) return -1;
      if (m_owner >= 0 && vbit(m_owner)) return m_owner;
      start = (m_owner >= 0) ? (m_owner + 1) % N : m_ptr;
      for (int k = 0; k < N; k++) begin
         if (vbit((start + k) % N)) return (start + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ov = 1'b0; m_data = 8'h00; m_id = 0;
      m_owner = -1; m_cnt = 0; m_ptr = 0; m_count = 0;
   endtask

   task automatic model_release();
      if (m_owner >= 0) begin
         m_ptr   = (m_owner + 1) % N;
         m_owner = -1;
         m_cnt   = 0;
      end
   endtask

   task automatic model_update();
      if (rst) begin
         model_reset();
      end else if (!m_ov || out_ready) begin
         if (m_g >= 0) begin
            m_ov    = 1'b1;
            m_data  = vbyte(m_g) ^ MASK;
            m_id    = m_g;
            m_count = (m_count + 1) % 65536;
            if (m_owner >= 0 && m_g == m_owner) begin
               m_cnt++;
               if (m_cnt == BURST) begin
                  m_owner = -1;
                  m_cnt   = 0;
                  m_ptr   = (m_g + 1) % N;
               end
            end else begin
               model_release();
               if (BURST == 1) m_ptr = (m_g + 1) % N;
               else begin
                  m_owner = m_g;
                  m_cnt   = 1;
               end
            end
         end else begin
            m_ov = 1'b0;
            model_release();
         end
      end
   endtask

   // One cycle: inputs were driven just after the previous rising edge.
   task automatic step();
      logic [N-1:0] e_rdy;
      #1;
      m_g   = model_grant();
      e_rdy = '0;
      if (m_g >= 0) e_rdy = N'(1) << m_g;
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      @(posedge clk);
      #1;
      model_update();
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("xfer_count", 32'(xfer_count), 32'(m_count));
      if (m_ov) begin
         chk("out_data", 32'(out_data), 32'(m_data));
         chk("out_id", 32'(out_id), 32'(m_id));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_id", 32'(out_id), 0);
      chk("rst_xfer_count", 32'(xfer_count), 0);
   endtask

   int seq [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

   initial begin
      rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Single requester, zero byte.
      req_valid = 4'b0001; req_data = '0; out_ready = 1'b1;
      step();
      chk("single_valid", 32'(out_valid), 1);
      chk("single_data", 32'(out_data), 32'h0000_00E1);
      chk("single_id", 32'(out_id), 0);
      chk("single_count", 32'(xfer_count), 1);

      // All valid: burst-of-two round robin.
      do_reset();
      req_valid = 4'hF;
      for (int k = 0; k < 10; k++) begin
         req_data = $urandom;
         step();
         chk("rr_seq_id", 32'(out_id), 32'(seq[k]));
      end

      // Owner 1 drops after one transfer; requester 3 served next cycle.
      do_reset();
      req_valid = 4'b0010; req_data = 32'h0000_4200;
      step();
      req_valid = 4'b1000; req_data = 32'h7700_0000;
      step();
      chk("handoff_id", 32'(out_id), 3);
      chk("handoff_data", 32'(out_data), 32'(8'h77 ^ MASK));
      chk("handoff_count", 32'(xfer_count), 2);

      // Downstream stall for three cycles.
      do_reset();
      req_valid = 4'b0001; req_data = 32'h0000_005A;
      step();
      out_ready = 1'b0; req_valid = 4'hF; req_data = 32'h1122_3344;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall_data", 32'(out_data), 32'h0000_00BB);
         chk("stall_id", 32'(out_id), 0);
         chk("stall_ready", 32'(req_ready), 0);
      end
      out_ready = 1'b1;
      step();
      chk("stall_resume_count", 32'(xfer_count), 2);
      chk("stall_resume_data", 32'(out_data), 32'(8'h44 ^ MASK));
      step();
      chk("stall_next_id", 32'(out_id), 1);

      // Reset while holding a stalled byte from owner 1.
      do_reset();
      req_valid = 4'b0010; req_data = 32'h0000_3300;
      step();
      out_ready = 1'b0; req_valid = '0;
      step();
      chk("prerst_valid", 32'(out_valid), 1);
      rst = 1'b1;
      step();
      chk("rst_drop_valid", 32'(out_valid), 0);
      rst = 1'b0; out_ready = 1'b1; req_valid = '0;
      step();
      chk("rst_no_emit", 32'(out_valid), 0);
      req_valid = 4'hF; req_data = 32'hA0B0_C0D0;
      step();
      chk("rst_ptr_zero_id", 32'(out_id), 0);

      // Counter wrap.
      do_reset();
      req_valid = 4'b0001; out_ready = 1'b1;
      for (int k = 0; k < 65535; k++) begin
         req_data = 32'(k);
         step();
      end
      chk("count_ffff", 32'(xfer_count), 32'h0000_FFFF);
      step();
      chk("count_wrap", 32'(xfer_count), 0);

      // Randomized traffic with occasional resets.
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         rst       = ($urandom_range(0, 199) == 0);
         req_valid = N'($urandom);
         req_data  = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/gate_bank_arbiter.md
GATE_BANK_ARBITER -- requirements
Module: gate_bank_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the 8-lane gate bank (2..8).
REQ-002 Parameter INV_MASK, default 8'hE1: per-lane inversion; bit set = lane inverts (lanes 0,5,6,7), clear = lane buffers (lanes 1-4).
REQ-003 Parameter BURST, default 2: maximum consecutive accepted transfers per grant before rotation (1..15).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req_valid  input  N_REQ  per-requester data valid.
REQ-007 req_data  input  8*N_REQ  requester i's byte at bits [8i+7:8i].
REQ-008 req_ready  output  N_REQ  per-requester accept; at most one bit high per cycle.
REQ-009 out_valid  output  1  gate bank output valid.
REQ-010 out_data  output  8  transformed byte.
REQ-011 out_id  output  3  index of the requester that sourced out_data.
REQ-012 out_ready  input  1  downstream accept.
REQ-013 xfer_count  output  16  total accepted transfers, wrapping.

Function
REQ-014 Transform SHALL be out_data = accepted req_data XOR INV_MASK, registered; latency from accept to out_valid is exactly 1 cycle.
REQ-015 Output slot SHALL load when (!out_valid | out_ready); load with no accepted request clears out_valid.
REQ-016 req_ready[i] SHALL equal load & grant[i]; a transfer occurs when req_valid[i] & req_ready[i].
REQ-017 Full throughput SHALL be sustained: one transfer per cycle while out_ready stays high.
REQ-018 Out_valid high with out_ready low SHALL hold out_data/out_id stable and all req_ready low.
REQ-019 FSM states: IDLE (no owner) and OWN (owner o, burst count c, 1..BURST).
REQ-020 IDLE: grant SHALL go to the first valid requester scanning circularly from pointer ptr.
REQ-021 IDLE transfer from winner w: if BURST==1, stay IDLE with ptr=w+1 mod N_REQ; otherwise go to OWN with o=w, c=1.
REQ-022 OWN with req_valid[o] high: grant only o; on transfer c increments; when c reaches BURST go to IDLE with ptr=o+1 mod N_REQ.
REQ-023 OWN with req_valid[o] low: same cycle SHALL arbitrate as IDLE with ptr=o+1 mod N_REQ (no dead cycle), state updating per REQ-021.
REQ-024 OWN while stalled (load low): state, o and c SHALL hold.
REQ-025 No requester valid during load: no grant, state and ptr unchanged except OWN releasing per REQ-023.
REQ-026 xfer_count SHALL increment by 1 per transfer, wrapping 16'hFFFF -> 16'h0000.

Reset
REQ-027 On rst: out_valid=0, out_data=8'h00, out_id=0, xfer_count=0, state=IDLE, ptr=0, c=0; req_ready low during the reset cycle.
REQ-028 Reset mid-transfer SHALL discard the held output byte and any ownership without emitting it.

Structure
REQ-029 Shared package SHALL hold the FSM state encoding, default INV_MASK (8'hE1) and default BURST.
REQ-030 One sub-module rr_pick SHALL implement the circular first-valid search (req vector, start pointer -> one-hot grant, found flag).

Verification
REQ-031 Single requester: req 0 sends 8'h00, out_ready=1 -> next cycle out_valid=1, out_data=8'hE1, out_id=0, xfer_count=1.
REQ-032 All four valid continuously, BURST=2, out_ready=1 -> out_id sequence 0,0,1,1,2,2,3,3,0,0.
REQ-033 Owner 1 drops valid after first transfer, req 3 valid -> next cycle grants 3 with no idle cycle.
REQ-034 out_ready low 3 cycles with out_valid=1 -> out_data/out_id stable, req_ready all 0; resume without loss or duplication.
REQ-035 Preload 65535 transfers then one more -> xfer_count wraps to 16'h0000.
REQ-036 rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, state IDLE, ptr=0, held byte never appears.
